// File: rtl/dds_phase_wave_gen_if.sv
// Test-tone sample bundle between the frequency/wave selector side and dds_phase_wave_gen.
// i_amplitude exists only when DDS_AMP_SCALE_EN is defined.
interface dds_phase_wave_gen_if #(
  parameter int PHASE_W  = 10,
  parameter int SAMPLE_W = 16
);
  logic                i_enable;
  logic                i_sample_tick;
  logic [PHASE_W-1:0]  i_phase_step;
`ifdef DDS_AMP_SCALE_EN
  logic [7:0]          i_amplitude;
`endif
  logic [SAMPLE_W-1:0] o_sample;
  logic                o_sample_valid;
  logic                o_period_start;
  logic [PHASE_W-1:0]  o_phase;

  modport master (
`ifdef DDS_AMP_SCALE_EN
    output i_amplitude,
`endif
    output i_enable, i_sample_tick, i_phase_step,
    input  o_sample, o_sample_valid, o_period_start, o_phase
  );

  modport slave (
`ifdef DDS_AMP_SCALE_EN
    input  i_amplitude,
`endif
    input  i_enable, i_sample_tick, i_phase_step,
    output o_sample, o_sample_valid, o_period_start, o_phase
  );
endinterface

// File: rtl/dds_phase_wave_gen.sv
// DDS tone source: phase accumulator + quarter-wave sine ROM; DDS_AMP_SCALE_EN adds an amplitude stage.
// Tick on edge E gives a valid sample after edge E+2 (E+3 with scaling); no backpressure, a tick may come every cycle.
module dds_phase_wave_gen #(
  parameter int PHASE_W   = 10,
  parameter int SAMPLE_W  = 16,
  parameter int ROM_DEPTH = 256
) (
  input logic                 i_clk,
  input logic                 i_rst,
  dds_phase_wave_gen_if.slave bus
);
  localparam int ADDR_W = PHASE_W - 2;
  // pi * 2^50, bit-exact with the double-precision constant
  localparam longint PI_Q50 = 64'sh000C_90FD_AA22_168C;

  // round(32767 * sin(2*pi*(k+0.5)/1024)) via a Q30 Taylor series at elaboration time
  function automatic logic [SAMPLE_W-1:0] rom_val(input int k);
    longint x, x2, term, acc;
    x    = (PI_Q50 * longint'(2 * k + 1)) >>> 30;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n < 12; n++) begin
      term = ((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      if (n % 2 == 1) acc = acc - term;
      else            acc = acc + term;
    end
    rom_val = SAMPLE_W'((acc * 32767 + (longint'(1) <<< 29)) >>> 30);
  endfunction

  logic [SAMPLE_W-1:0] rom_tbl [ROM_DEPTH];
  for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
    localparam logic [SAMPLE_W-1:0] VAL = rom_val(k);
    assign rom_tbl[k] = VAL;
  end

  logic [PHASE_W-1:0]  phase_acc_q, phase_acc_d, step_q, step_d, p0_q;
  logic                pend_q, pend_d, s0_q, v0_q;
  logic [PHASE_W:0]    sum;
  logic                fire;
  logic [ADDR_W-1:0]   rom_addr;
  logic [SAMPLE_W-1:0] rom_q, sample2_q;
  logic                sign1_q, s1_q, v1_q, valid2_q, pstart2_q;

  assign fire     = bus.i_enable & bus.i_sample_tick;
  assign sum      = {1'b0, phase_acc_q} + {1'b0, step_q};
  assign rom_addr = p0_q[ADDR_W] ? ~p0_q[ADDR_W-1:0] : p0_q[ADDR_W-1:0];

  // The step is only swapped at a period boundary so a period is never distorted mid-cycle.
  always_comb begin
    phase_acc_d = phase_acc_q;
    step_d      = step_q;
    pend_d      = pend_q;
    if (!bus.i_enable) begin
      phase_acc_d = '0;
      pend_d      = 1'b1;
      step_d      = bus.i_phase_step;
    end else if (bus.i_sample_tick) begin
      phase_acc_d = sum[PHASE_W-1:0];
      pend_d      = sum[PHASE_W];
      if (sum[PHASE_W] || (step_q == '0)) step_d = bus.i_phase_step;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase_acc_q <= '0;
      step_q      <= PHASE_W'(1);
      pend_q      <= 1'b1;
      p0_q        <= '0;
      s0_q        <= 1'b0;
      v0_q        <= 1'b0;
      rom_q       <= '0;
      sign1_q     <= 1'b0;
      s1_q        <= 1'b0;
      v1_q        <= 1'b0;
      sample2_q   <= '0;
      valid2_q    <= 1'b0;
      pstart2_q   <= 1'b0;
    end else begin
      phase_acc_q <= phase_acc_d;
      step_q      <= step_d;
      pend_q      <= pend_d;
      v0_q        <= fire;
      if (fire) begin
        p0_q <= phase_acc_q;
        s0_q <= pend_q;
      end
      rom_q     <= rom_tbl[rom_addr];
      sign1_q   <= p0_q[PHASE_W-1];
      s1_q      <= s0_q;
      v1_q      <= v0_q;
      valid2_q  <= v1_q;
      pstart2_q <= s1_q & v1_q;
      if (v1_q) sample2_q <= sign1_q ? -rom_q : rom_q;
    end
  end

`ifdef DDS_AMP_SCALE_EN
  logic [7:0]              amp2_q;
  logic [SAMPLE_W-1:0]     sample3_q;
  logic                    valid3_q, pstart3_q;
  logic signed [SAMPLE_W+8:0] prod;

  // Arithmetic shift of the signed product floors toward negative infinity.
  assign prod = $signed(sample2_q) * $signed({1'b0, amp2_q});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      amp2_q    <= '0;
      sample3_q <= '0;
      valid3_q  <= 1'b0;
      pstart3_q <= 1'b0;
    end else begin
      if (v1_q) amp2_q <= bus.i_amplitude;
      if (valid2_q) sample3_q <= prod[SAMPLE_W+7:8];
      valid3_q  <= valid2_q;
      pstart3_q <= pstart2_q;
    end
  end

  assign bus.o_sample       = sample3_q;
  assign bus.o_sample_valid = valid3_q;
  assign bus.o_period_start = pstart3_q;
`else
  assign bus.o_sample       = sample2_q;
  assign bus.o_sample_valid = valid2_q;
  assign bus.o_period_start = pstart2_q;
`endif
  assign bus.o_phase = phase_acc_q;

endmodule

// File: tb/tb_dds_phase_wave_gen.sv
// Bench for dds_phase_wave_gen: sine/phase model from first principles plus directed literal checks.
module tb_dds_phase_wave_gen;
  localparam int PW = 10;
  localparam int SW = 16;
`ifdef DDS_AMP_SCALE_EN
  localparam int LAT = 3;
  localparam int AMP = 255;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dds_phase_wave_gen_if #(.PHASE_W(PW), .SAMPLE_W(SW)) bus ();
  dds_phase_wave_gen #(.PHASE_W(PW), .SAMPLE_W(SW), .ROM_DEPTH(256)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic int scl(input int s);
`ifdef DDS_AMP_SCALE_EN
    return (s * AMP) >>> 8;
`else
    return s;
`endif
  endfunction

  function automatic int sine_of(input int p);
    real v;
    v = 32767.0 * $sin(2.0 * 3.14159265358979 * (real'(p) + 0.5) / 1024.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  typedef struct {
    int phase;
    bit pstart;
    int due;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   m_phase = 0;
  int   m_step  = 1;
  bit   m_pend  = 1'b1;
  int   cyc     = 0;
  int   nxt;
  bit   chk_on  = 1'b0;
  int   log_s[$];
  bit   log_ps[$];

  // Model: phase/step rules applied to the inputs seen at each rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      m_phase = 0;
      m_step  = 1;
      m_pend  = 1'b1;
    end else if (!bus.i_enable) begin
      m_phase = 0;
      m_pend  = 1'b1;
      m_step  = int'(bus.i_phase_step);
    end else if (bus.i_sample_tick) begin
      q.push_back('{m_phase, m_pend, cyc + LAT});
      nxt    = m_phase + m_step;
      m_pend = (nxt >= 1024);
      if (nxt >= 1024 || m_step == 0) m_step = int'(bus.i_phase_step);
      m_phase = nxt % 1024;
    end
  end

  // Compare process on the falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        cur = q.pop_front();
        check("valid", int'(bus.o_sample_valid), 1);
        check("sample", int'($signed(bus.o_sample)), scl(sine_of(cur.phase)));
        check("period_start", int'(bus.o_period_start), int'(cur.pstart));
      end else begin
        check("idle_valid", int'(bus.o_sample_valid), 0);
      end
      check("phase", int'(bus.o_phase), m_phase);
      if (bus.o_sample_valid) begin
        log_s.push_back(int'($signed(bus.o_sample)));
        log_ps.push_back(bus.o_period_start);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_sample_tick = 1'b1;
      for (int g = 1; g < gap; g++) begin
        @(negedge clk);
        bus.i_sample_tick = 1'b0;
      end
    end
    @(negedge clk);
    bus.i_sample_tick = 1'b0;
  endtask

  task automatic load_step(input int s);
    @(negedge clk);
    bus.i_enable     = 1'b0;
    bus.i_phase_step = PW'(s);
    @(negedge clk);
    bus.i_enable = 1'b1;
  endtask

  function automatic int count_ps();
    int c = 0;
    foreach (log_ps[i]) c += int'(log_ps[i]);
    return c;
  endfunction

  int sym_bad;

  initial begin
    bus.i_enable      = 1'b0;
    bus.i_sample_tick = 1'b0;
    bus.i_phase_step  = PW'(1);
`ifdef DDS_AMP_SCALE_EN
    bus.i_amplitude   = 8'(AMP);
`endif
    repeat (2) @(posedge clk);
    chk_on = 1'b1;
    idle(2);
    check("rst_valid", int'(bus.o_sample_valid), 0);
    check("rst_sample", int'(bus.o_sample), 0);
    check("rst_pstart", int'(bus.o_period_start), 0);
    check("rst_phase", int'(bus.o_phase), 0);
    rst = 1'b0;

    // 1: step 1, tick every 4 cycles, one full period plus one
    idle(2);
    log_s.delete(); log_ps.delete();
    bus.i_enable = 1'b1;
    ticks(1025, 4);
    idle(6);
    check("t1_count", log_s.size(), 1025);
    if (log_s.size() == 1025) begin
      check("t1_first", log_s[0], scl(101));
      check("t1_first_ps", int'(log_ps[0]), 1);
      check("t1_peak", log_s[256], scl(32767));
      check("t1_half", log_s[512], scl(-101));
      check("t1_trough", log_s[768], scl(-32767));
      check("t1_wrap_ps", int'(log_ps[1024]), 1);
    end
    check("t1_ps_total", count_ps(), 2);

    // 2: step 4, tick every cycle
    load_step(4);
    log_s.delete(); log_ps.delete();
    ticks(520, 1);
    idle(6);
    check("t2_count", log_s.size(), 520);
    check("t2_ps_total", count_ps(), 3);
    if (log_s.size() == 520) begin
      check("t2_ps_256", int'(log_ps[256]), 1);
      check("t2_phase4", log_s[1], scl(905));
      sym_bad = 0;
      for (int i = 0; i < 128; i++) begin
`ifdef DDS_AMP_SCALE_EN
        if (log_s[i] + log_s[i+128] != 0 && log_s[i] + log_s[i+128] != -1) sym_bad++;
`else
        if (log_s[i] != -log_s[i+128]) sym_bad++;
`endif
      end
      check("t2_symmetry", sym_bad, 0);
    end

    // 3: step 1 -> 4 requested at phase 100 only takes effect after the wrap
    load_step(1);
    log_s.delete(); log_ps.delete();
    ticks(100, 1);
    check("t3_phase100", int'(bus.o_phase), 100);
    bus.i_phase_step = PW'(4);
    ticks(927, 1);
    idle(6);
    check("t3_phase_end", int'(bus.o_phase), 12);
    check("t3_count", log_s.size(), 1027);
    if (log_s.size() == 1027) begin
      check("t3_p1023", log_s[1023], scl(-101));
      check("t3_wrap", log_s[1024], scl(101));
      check("t3_wrap_ps", int'(log_ps[1024]), 1);
      check("t3_p4", log_s[1025], scl(905));
      check("t3_p4_ps", int'(log_ps[1025]), 0);
    end

    // 4: enable dropped at phase 300 with two samples in flight
    load_step(1);
    log_s.delete(); log_ps.delete();
    ticks(300, 1);
    check("t4_phase300", int'(bus.o_phase), 300);
    bus.i_enable = 1'b0;
    idle(5);
    check("t4_drained", log_s.size(), 300);
    check("t4_phase0", int'(bus.o_phase), 0);
    log_s.delete(); log_ps.delete();
    bus.i_enable = 1'b1;
    ticks(3, 2);
    idle(5);
    check("t4_count", log_s.size(), 3);
    if (log_s.size() == 3) begin
      check("t4_first", log_s[0], scl(101));
      check("t4_first_ps", int'(log_ps[0]), 1);
    end

    // 5: reset one cycle after a tick discards the in-flight sample
    log_s.delete(); log_ps.delete();
    @(negedge clk);
    bus.i_sample_tick = 1'b1;
    @(negedge clk);
    bus.i_sample_tick = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    check("t5_no_valid", log_s.size(), 0);
    check("t5_sample", int'(bus.o_sample), 0);
    check("t5_phase", int'(bus.o_phase), 0);

    // 6: step 0 picked up at the wrap, reloaded on the next tick
    load_step(2);
    ticks(511, 1);
    check("t6_phase1022", int'(bus.o_phase), 1022);
    bus.i_phase_step = PW'(0);
    ticks(1, 1);
    check("t6_wrapped", int'(bus.o_phase), 0);
    bus.i_phase_step = PW'(2);
    idle(5);
    log_s.delete(); log_ps.delete();
    ticks(3, 1);
    idle(5);
    check("t6_phase_end", int'(bus.o_phase), 4);
    check("t6_count", log_s.size(), 3);
    if (log_s.size() == 3) begin
      check("t6_dc0", log_s[0], scl(101));
      check("t6_dc0_ps", int'(log_ps[0]), 1);
      check("t6_dc1", log_s[1], scl(101));
      check("t6_dc1_ps", int'(log_ps[1]), 0);
      check("t6_p2", log_s[2], scl(503));
    end

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
